square_draw_scheduler: RTL and testbench
========================================

# square_draw_scheduler

Shares the 4x4 square rasteriser (one VGA pixel per clock) among up to NREQ requesters, such as note lanes, the drum-hit marker and the score display. Each requester posts a base coordinate, colour and draw/erase flag, then holds its request. The scheduler grants requesters round-robin, latches the winner's fields and sweeps the 16 pixels in row-major order onto the VGA adapter's x/y/colour/plot inputs. It then pulses an acknowledge to the winner. It sits between the game-logic requesters and the VGA adapter, and is the only block that drives the adapter's write port.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 3, width of grant_id; must satisfy 2^IDW >= NREQ
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  reset, synchronous, active-low
- req  in  NREQ  per-requester draw request; held high until its ack
- x_in  in  8*NREQ  base x of square; requester i at bits [8i+7:8i]
- y_in  in  7*NREQ  base y; requester i at [7i+6:7i]
- colour_in  in  3*NREQ  colour; requester i at [3i+2:3i]
- erase_in  in  NREQ  1 = paint square black, ignoring colour_in
- ack  out  NREQ  one-cycle completion pulse to the granted requester
- busy  out  1  high in every state except IDLE
- grant_id  out  IDW  index of the current/last granted requester
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel colour
- vga_plot  out  1  pixel write enable

## Operation
- States: IDLE, DRAW, DONE.
- **IDLE**
  - If any req bit is high, pick a winner by round-robin. Search starts at index (last_grant+1) mod NREQ and wraps.
  - On the transition edge: latch the winner's x, y, effective colour and index into internal registers; clear the pixel counter; go to DRAW.
  - If no req bit is high, stay in IDLE.
- **DRAW**
  - 4-bit pixel counter p runs 0..15: xoff = p[1:0], yoff = p[3:2].
  - vga_plot = 1.
  - vga_x = (bx + xoff) mod 256 and vga_y = (by + yoff) mod 128. Wrap-around is permitted and not flagged.
  - vga_colour = 3'b000 if the latched erase bit = 1, else the latched colour.
  - When p = 15, go to DONE on the next edge.
- **DONE**
  - vga_plot = 0; ack[grant_id] = 1 for exactly this cycle; update last_grant to grant_id; go to IDLE.
- Input changes while busy are ignored, because the operation uses only the latched copies.
- A requester that drops req before its grant is simply not served; no error is raised.
- Requests arriving during DRAW/DONE wait. They are evaluated in the next IDLE cycle.
- A req bit still high in IDLE after its ack is treated as a new request, at the lowest rotation priority.
- All outputs are driven from registers or from state/counter/latched values. There is no combinational path from any input to any output.

## Timing
- **Reset** (resetn low at a clk edge):
  - state = IDLE, p = 0, last_grant = NREQ-1, so index 0 has first priority.
  - grant_id = 0, vga_x = 0, vga_y = 0, vga_colour = 0, vga_plot = 0, ack = 0, busy = 0.
- **Reset mid-DRAW or mid-DONE:** abort immediately. No ack is issued, and no further plot occurs from the next cycle on.
- **Latency:**
  - req seen high in IDLE at cycle 0 → first pixel plotted at cycle 1, last pixel at cycle 16, ack at cycle 17, IDLE again at cycle 18.
  - Back-to-back service costs 18 cycles per square, with exactly one IDLE cycle between squares.
- **Handshake:** the requester samples ack at an edge and may deassert req at that same edge. The scheduler's following IDLE cycle then sees req low.
- **Simultaneous requests:** exactly one grant per IDLE cycle. ack is never asserted for more than one bit.

## Test plan
- **Single request:** reset; req=0001, x_in[0]=10, y_in[0]=20, colour=3'b110, erase=0. Required: plot high cycles 1–16; pixels (10,20),(11,20),(12,20),(13,20),(10,21)…(13,23), all colour 110; ack=0001 at cycle 17 only; busy low at cycle 18.
- **Erase:** same square with erase=1, colour=3'b111 → all 16 pixels have colour 000.
- **Round-robin:** req=1111 held, each requester dropping req on its ack. Required: grant order 0,1,2,3; each ack 18 cycles apart. Re-raising req0 during requester 3's service makes 0 granted next.
- **Wrap:** x=254, y=126 → x sequence 254,255,0,1; y sequence 126,127,0,1; no hang.
- **Input stability:** change x_in[0] to 50 at cycle 5 of a draw → remaining pixels still use base x 10.
- **Reset mid-draw:** assert resetn=0 at cycle 8 → next cycle vga_plot=0 and busy=0, no ack ever for that request; after release, a held req0 is served from scratch with first pixel (10,20).

Source files
------------

// File: rtl/square_draw_scheduler_if.sv
// rtl/square_draw_scheduler_if.sv - requester/VGA bundle for the shared square rasteriser
//
// Purpose: groups every signal between the game-logic requesters, the
//          square_draw_scheduler and the VGA adapter write port.
// Signals:
//   req        per-requester draw request, held until its ack
//   x_in       packed 8-bit base x, requester i at [8i+7:8i]
//   y_in       packed 7-bit base y, requester i at [7i+6:7i]
//   colour_in  packed 3-bit colour, requester i at [3i+2:3i]
//   erase_in   per-requester erase flag (paint black)
//   ack        one-cycle completion pulse to the served requester
//   busy       scheduler not idle
//   grant_id   current/last granted requester index
//   vga_x/vga_y/vga_colour/vga_plot  adapter write port
// Modports: master = requester/adapter side, slave = scheduler side.

interface square_draw_scheduler_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 3
);
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] x_in;
   logic [7*NREQ-1:0] y_in;
   logic [3*NREQ-1:0] colour_in;
   logic [NREQ-1:0]   erase_in;
   logic [NREQ-1:0]   ack;
   logic              busy;
   logic [IDW-1:0]    grant_id;
   logic [7:0]        vga_x;
   logic [6:0]        vga_y;
   logic [2:0]        vga_colour;
   logic              vga_plot;

   modport master (
      output req, x_in, y_in, colour_in, erase_in,
      input  ack, busy, grant_id, vga_x, vga_y, vga_colour, vga_plot
   );

   modport slave (
      input  req, x_in, y_in, colour_in, erase_in,
      output ack, busy, grant_id, vga_x, vga_y, vga_colour, vga_plot
   );
endinterface

// File: rtl/square_draw_scheduler.sv
// rtl/square_draw_scheduler.sv - round-robin scheduler driving the 4x4 square rasteriser
//
// Purpose: shares one 4x4 square rasteriser (one pixel per clock) among NREQ
//          requesters. A requester is granted round-robin in IDLE, its fields
//          are latched, 16 pixels are swept row-major in DRAW and a one-cycle
//          ack is pulsed in DONE.
// Ports:
//   clk     system clock
//   resetn  synchronous active-low reset
//   bus     square_draw_scheduler_if.slave: requests/fields in, ack/busy/
//           grant_id and VGA adapter write port out
// Parameters:
//   NREQ  number of requesters (2..8)
//   IDW   grant index width, 2**IDW >= NREQ

module square_draw_scheduler #(
   parameter int NREQ = 4,
   parameter int IDW  = 3
) (
   input logic                   clk,
   input logic                   resetn,
   square_draw_scheduler_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DRAW = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   // Pixel counter: low two bits are the column offset, high two the row.
   logic [3:0]     pix;
   logic [IDW-1:0] last_grant;
   logic [IDW-1:0] grant_q;
   logic [7:0]     base_x;
   logic [6:0]     base_y;
   logic [2:0]     base_colour;

   // Winner selection and the winner's fields, valid only in IDLE.
   logic           win_found;
   logic [IDW-1:0] win_idx;
   logic [7:0]     win_x;
   logic [6:0]     win_y;
   logic [2:0]     win_colour;

   // Round-robin search: candidates are visited starting just after the last
   // served requester, so a requester that was just served is visited last.
   always_comb begin
      int cand;
      int sel;
      cand      = 0;
      sel       = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = (int'(last_grant) + k) % NREQ;
         if (!win_found && bus.req[cand]) begin
            win_found = 1'b1;
            sel       = cand;
         end
      end
      win_idx = IDW'(sel);
      win_x   = bus.x_in[8*sel +: 8];
      win_y   = bus.y_in[7*sel +: 7];
      // Erase is folded into the latched colour so DRAW needs no erase bit.
      win_colour = bus.erase_in[sel] ? 3'b000 : bus.colour_in[3*sel +: 3];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (win_found) begin
               state_nxt = S_DRAW;
            end
         end
         S_DRAW: begin
            if (pix == 4'd15) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath registers: latched request, pixel counter, rotation pointer.
   // Inputs are only looked at on the IDLE->DRAW edge, so requesters may
   // change their fields freely while a square is being drawn.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         pix         <= 4'd0;
         last_grant  <= IDW'(NREQ - 1);
         grant_q     <= '0;
         base_x      <= 8'd0;
         base_y      <= 7'd0;
         base_colour <= 3'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (win_found) begin
                  grant_q     <= win_idx;
                  base_x      <= win_x;
                  base_y      <= win_y;
                  base_colour <= win_colour;
                  pix         <= 4'd0;
               end
            end
            S_DRAW: begin
               pix <= pix + 4'd1;
            end
            S_DONE: begin
               last_grant <= grant_q;
            end
            default: begin
               pix <= 4'd0;
            end
         endcase
      end
   end

   // Outputs depend only on state and registers; no input reaches an output
   // combinationally. Coordinates wrap naturally through the fixed widths.
   always_comb begin
      bus.busy       = (state != S_IDLE);
      bus.grant_id   = grant_q;
      bus.vga_plot   = 1'b0;
      bus.vga_x      = 8'd0;
      bus.vga_y      = 7'd0;
      bus.vga_colour = 3'd0;
      bus.ack        = '0;
      if (state == S_DRAW) begin
         bus.vga_plot   = 1'b1;
         bus.vga_x      = base_x + {6'd0, pix[1:0]};
         bus.vga_y      = base_y + {5'd0, pix[3:2]};
         bus.vga_colour = base_colour;
      end
      for (int i = 0; i < NREQ; i++) begin
         bus.ack[i] = (state == S_DONE) && (grant_q == IDW'(i));
      end
   end

endmodule

// File: tb/tb_square_draw_scheduler.sv
// tb/tb_square_draw_scheduler.sv - self-checking bench for square_draw_scheduler

module tb_square_draw_scheduler;
   localparam int NREQ = 4;
   localparam int IDW  = 3;

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   square_draw_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   square_draw_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: a service is described by the cycle count t since the
   // grant (-1 = nothing in progress). Pixels occupy t=0..15, the ack t=16.
   bit m_valid = 1'b0;
   int m_t     = -1;
   int m_g     = 0;
   int m_last  = NREQ - 1;
   int m_bx, m_by, m_col;

   always @(negedge clk) begin
      int drawing;
      int cand;
      bit found;
      drawing = (m_t >= 0 && m_t < 16) ? 1 : 0;
      if (m_valid) begin
         check("m_busy", int'(bus.busy), (m_t >= 0) ? 1 : 0);
         check("m_plot", int'(bus.vga_plot), drawing);
         check("m_ack", int'(bus.ack), (m_t == 16) ? (1 << m_g) : 0);
         check("m_grant", int'(bus.grant_id), m_g);
         if (drawing != 0) begin
            check("m_x", int'(bus.vga_x), (m_bx + m_t % 4) % 256);
            check("m_y", int'(bus.vga_y), (m_by + m_t / 4) % 128);
            check("m_col", int'(bus.vga_colour), m_col);
         end
      end
      // Advance the model to what the next clock edge will produce.
      if (!resetn) begin
         m_t    = -1;
         m_g    = 0;
         m_last = NREQ - 1;
      end else if (m_t < 0) begin
         found = 1'b0;
         for (int k = 1; k <= NREQ; k++) begin
            cand = (m_last + k) % NREQ;
            if (!found && bus.req[cand]) begin
               found = 1'b1;
               m_g   = cand;
               m_bx  = int'(bus.x_in[8*cand +: 8]);
               m_by  = int'(bus.y_in[7*cand +: 7]);
               m_col = bus.erase_in[cand] ? 0 : int'(bus.colour_in[3*cand +: 3]);
               m_t   = 0;
            end
         end
      end else if (m_t == 16) begin
         m_last = m_g;
         m_t    = -1;
      end else begin
         m_t++;
      end
      m_valid = 1'b1;
   end

   int px[16];
   int py[16];
   int pc[16];

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Requester 0 draws one square starting from an idle scheduler; the
   // current cycle is cycle 0. If chg is nonzero, x_in[0] is changed to 50
   // after that pixel cycle.
   task automatic draw_check(input string tag, input int bx, input int by,
                             input int col, input bit er, input int chg);
      bus.x_in[7:0]      = 8'(bx);
      bus.y_in[6:0]      = 7'(by);
      bus.colour_in[2:0] = 3'(col);
      bus.erase_in[0]    = er;
      bus.req[0]         = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         step();
         px[k-1] = int'(bus.vga_x);
         py[k-1] = int'(bus.vga_y);
         pc[k-1] = int'(bus.vga_colour);
         check({tag, " plot"}, int'(bus.vga_plot), 1);
         check({tag, " x"}, px[k-1], (bx + (k - 1) % 4) % 256);
         check({tag, " y"}, py[k-1], (by + (k - 1) / 4) % 128);
         check({tag, " colour"}, pc[k-1], er ? 0 : col);
         check({tag, " early ack"}, int'(bus.ack), 0);
         if (k == chg) bus.x_in[7:0] = 8'd50;
      end
      step();
      check({tag, " ack17"}, int'(bus.ack), 1);
      check({tag, " plot17"}, int'(bus.vga_plot), 0);
      bus.req[0] = 1'b0;
      step();
      check({tag, " busy18"}, int'(bus.busy), 0);
   endtask

   task automatic wait_ack(output int val, output int n);
      n   = 0;
      val = 0;
      while (n < 60) begin
         step();
         n++;
         if (bus.ack != '0) begin
            val = int'(bus.ack);
            break;
         end
      end
      if (val == 0) check("ack timeout", 0, 1);
   endtask

   initial begin
      int v;
      int n;
      bus.req       = '0;
      bus.x_in      = '0;
      bus.y_in      = '0;
      bus.colour_in = '0;
      bus.erase_in  = '0;
      resetn        = 1'b0;
      step();
      step();
      check("rst grant_id", int'(bus.grant_id), 0);
      check("rst vga_x", int'(bus.vga_x), 0);
      check("rst vga_y", int'(bus.vga_y), 0);
      check("rst colour", int'(bus.vga_colour), 0);
      check("rst plot", int'(bus.vga_plot), 0);
      check("rst ack", int'(bus.ack), 0);
      check("rst busy", int'(bus.busy), 0);
      resetn = 1'b1;
      step();

      draw_check("single", 10, 20, 6, 1'b0, 0);
      check("single p0x", px[0], 10);
      check("single p0y", py[0], 20);
      check("single p4x", px[4], 10);
      check("single p4y", py[4], 21);
      check("single p15x", px[15], 13);
      check("single p15y", py[15], 23);
      check("single p15c", pc[15], 6);

      draw_check("erase", 10, 20, 7, 1'b1, 0);
      check("erase p0c", pc[0], 0);

      draw_check("wrap", 254, 126, 5, 1'b0, 0);
      check("wrap p1x", px[1], 255);
      check("wrap p2x", px[2], 0);
      check("wrap p3x", px[3], 1);
      check("wrap p8y", py[8], 0);
      check("wrap p12y", py[12], 1);

      draw_check("stable", 10, 20, 3, 1'b0, 5);
      check("stable p15x", px[15], 13);
      check("stable p6x", px[6], 12);

      // Reset in the middle of a draw.
      bus.x_in[7:0]   = 8'd10;
      bus.y_in[6:0]   = 7'd20;
      bus.erase_in[0] = 1'b0;
      bus.req[0]      = 1'b1;
      repeat (8) step();
      check("mid plot8", int'(bus.vga_plot), 1);
      resetn = 1'b0;
      step();
      check("mid plot9", int'(bus.vga_plot), 0);
      check("mid busy9", int'(bus.busy), 0);
      check("mid ack9", int'(bus.ack), 0);
      resetn = 1'b1;
      step();
      check("mid restart plot", int'(bus.vga_plot), 1);
      check("mid restart x", int'(bus.vga_x), 10);
      check("mid restart y", int'(bus.vga_y), 20);
      wait_ack(v, n);
      check("mid ack val", v, 1);
      check("mid ack lat", n, 16);
      bus.req[0] = 1'b0;
      step();

      // Round-robin with all four requesting.
      resetn = 1'b0;
      step();
      resetn        = 1'b1;
      bus.x_in      = 32'($urandom);
      bus.y_in      = 28'($urandom);
      bus.colour_in = 12'($urandom);
      bus.req       = 4'b1111;
      wait_ack(v, n);
      check("rr ack0", v, 1);
      check("rr lat0", n, 17);
      bus.req[0] = 1'b0;
      wait_ack(v, n);
      check("rr ack1", v, 2);
      check("rr gap1", n, 18);
      bus.req[1] = 1'b0;
      wait_ack(v, n);
      check("rr ack2", v, 4);
      check("rr gap2", n, 18);
      bus.req[2] = 1'b0;
      repeat (5) step();
      bus.req[0] = 1'b1;
      bus.req[2] = 1'b1;
      wait_ack(v, n);
      check("rr ack3", v, 8);
      check("rr gap3", n, 13);
      bus.req[3] = 1'b0;
      wait_ack(v, n);
      check("rr ack0 again", v, 1);
      check("rr gap4", n, 18);
      bus.req[0] = 1'b0;
      wait_ack(v, n);
      check("rr ack2 again", v, 4);
      check("rr gap5", n, 18);
      bus.req[2] = 1'b0;
      step();

      // Random traffic, checked by the model every cycle.
      for (int c = 0; c < 4000; c++) begin
         step();
         if (!resetn) resetn = 1'b1;
         else if ($urandom_range(0, 399) == 0) resetn = 1'b0;
         for (int i = 0; i < NREQ; i++) begin
            if (bus.ack[i]) bus.req[i] = 1'b0;
            else if (!bus.req[i]) begin
               if ($urandom_range(0, 5) == 0) bus.req[i] = 1'b1;
            end else if ($urandom_range(0, 99) == 0) bus.req[i] = 1'b0;
         end
         if ($urandom_range(0, 3) == 0) bus.x_in = 32'($urandom);
         if ($urandom_range(0, 3) == 0) bus.y_in = 28'($urandom);
         if ($urandom_range(0, 3) == 0) bus.colour_in = 12'($urandom);
         if ($urandom_range(0, 3) == 0) bus.erase_in = 4'($urandom);
      end
      resetn  = 1'b1;
      bus.req = '0;
      repeat (40) step();
      check("final busy", int'(bus.busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
